// File: rtl/fizzbuzz_formatter_if.sv
// Result-in / byte-out signal bundle for the fizzbuzz formatter.
// The producer/sink side uses master; the formatter uses slave.
`timescale 1ns/1ps
interface fizzbuzz_formatter_if #(
    parameter int unsigned g_width = 6
);
    logic               i_valid;
    logic               i_is_fizz;
    logic               i_is_buzz;
    logic [g_width-1:0] i_number;
    logic               i_ready;
    logic               o_full;
    logic               o_empty;
    logic               o_overflow;
    logic               o_busy;
    logic               o_valid;
    logic [7:0]         o_data;

    modport master (
        output i_valid, i_is_fizz, i_is_buzz, i_number, i_ready,
        input  o_full, o_empty, o_overflow, o_busy, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_is_fizz, i_is_buzz, i_number, i_ready,
        output o_full, o_empty, o_overflow, o_busy, o_valid, o_data
    );
endinterface

// File: rtl/fizzbuzz_formatter.sv
// Buffers fizzbuzz results in a FIFO and streams each one out as an ASCII line
// ("Fizz", "Buzz", "FizzBuzz" or decimal digits, then LF) over valid/ready.
`timescale 1ns/1ps
module fizzbuzz_formatter #(
    parameter int unsigned g_width = 6,
    parameter int unsigned g_depth = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    fizzbuzz_formatter_if.slave bus
);
    localparam int unsigned AW = (g_depth > 1) ? $clog2(g_depth) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 10;
    localparam logic [7:0]  LF = 8'h0A;

    typedef struct packed {
        logic               fizz;
        logic               buzz;
        logic [g_width-1:0] number;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NUM  = 2'd0,
        K_FIZZ = 2'd1,
        K_BUZZ = 2'd2,
        K_FB   = 2'd3
    } kind_t;

    entry_t             mem_q [g_depth];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, empty_q, overflow_q;
    logic               push_c, pop_c;
    entry_t             wr_entry_c, head_c;

    state_t             state_q;
    kind_t              kind_q;
    logic [g_width-1:0] rem_q;
    logic [3:0]         h_q, t_q, ones_q;
    logic [3:0]         idx_q;
    logic               valid_q, busy_q;
    logic [7:0]         data_q;
    logic [RW-1:0]      rem_ext_c;
    logic [7:0]         next_byte_c;
    logic               last_c;

    function automatic logic [7:0] text_byte(input logic is_buzz, input logic [1:0] pos);
        logic [7:0] b;
        case (pos)
            2'd0:    b = is_buzz ? 8'h42 : 8'h46;
            2'd1:    b = is_buzz ? 8'h75 : 8'h69;
            default: b = 8'h7A;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] num_digits(input logic [3:0] h, input logic [3:0] t);
        logic [3:0] n;
        if (h != 4'd0)      n = 4'd3;
        else if (t != 4'd0) n = 4'd2;
        else                n = 4'd1;
        return n;
    endfunction

    // Byte at position idx of the current line; anything past the payload is LF.
    function automatic logic [7:0] line_byte(input kind_t k, input logic [3:0] h,
                                             input logic [3:0] t, input logic [3:0] o,
                                             input logic [3:0] idx);
        logic [7:0] b;
        logic [3:0] nd;
        logic [3:0] pos;
        logic [3:0] d;
        b   = LF;
        nd  = num_digits(h, t);
        pos = 4'(idx + 4'd3 - nd);
        d   = o;
        case (k)
            K_FIZZ: if (idx < 4'd4) b = text_byte(1'b0, idx[1:0]);
            K_BUZZ: if (idx < 4'd4) b = text_byte(1'b1, idx[1:0]);
            K_FB:   if (idx < 4'd8) b = text_byte(idx[2], idx[1:0]);
            default: begin
                if (idx < nd) begin
                    case (pos)
                        4'd0:    d = h;
                        4'd1:    d = t;
                        default: d = o;
                    endcase
                    b = 8'h30 + {4'h0, d};
                end
            end
        endcase
        return b;
    endfunction

    function automatic logic [3:0] last_idx(input kind_t k, input logic [3:0] h, input logic [3:0] t);
        logic [3:0] li;
        case (k)
            K_FIZZ:  li = 4'd4;
            K_BUZZ:  li = 4'd4;
            K_FB:    li = 4'd8;
            default: li = num_digits(h, t);
        endcase
        return li;
    endfunction

    assign wr_entry_c = '{fizz: bus.i_is_fizz, buzz: bus.i_is_buzz, number: bus.i_number};
    assign head_c     = mem_q[rd_ptr_q];
    assign push_c     = bus.i_valid && !full_q;
    assign pop_c      = (state_q == S_IDLE) && !empty_q;
    assign rem_ext_c  = RW'(rem_q);

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_c && pop_c) count_d = count_q - CW'(1);
    end

    // Byte to present next: the first byte when priming, otherwise the one after idx.
    always_comb begin
        next_byte_c = line_byte(kind_q, h_q, t_q, ones_q, valid_q ? 4'(idx_q + 4'd1) : idx_q);
        last_c      = (idx_q == last_idx(kind_q, h_q, t_q));
    end

    // FIFO pointers and flags; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(g_depth));
            empty_q <= (count_d == '0);
            if (bus.i_valid && full_q) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_c) mem_q[wr_ptr_q] <= wr_entry_c;
    end

    // Serializer: pop, optional repeated-subtraction BCD conversion, then byte emission.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_NUM;
            rem_q   <= '0;
            h_q     <= '0;
            t_q     <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (head_c.fizz || head_c.buzz) begin
                            kind_q  <= (head_c.fizz && head_c.buzz) ? K_FB :
                                       (head_c.fizz ? K_FIZZ : K_BUZZ);
                            state_q <= S_EMIT;
                        end else begin
                            kind_q  <= K_NUM;
                            rem_q   <= head_c.number;
                            h_q     <= '0;
                            t_q     <= '0;
                            state_q <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    if (rem_ext_c >= RW'(100)) begin
                        rem_q <= g_width'(rem_ext_c - RW'(100));
                        h_q   <= h_q + 4'd1;
                    end else if (rem_ext_c >= RW'(10)) begin
                        rem_q <= g_width'(rem_ext_c - RW'(10));
                        t_q   <= t_q + 4'd1;
                    end else begin
                        ones_q  <= rem_ext_c[3:0];
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        data_q  <= next_byte_c;
                    end else if (bus.i_ready) begin
                        if (last_c) begin
                            valid_q <= 1'b0;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            data_q <= next_byte_c;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_full     = full_q;
    assign bus.o_empty    = empty_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;

endmodule

// File: tb/tb_fizzbuzz_formatter.sv
// Directed bench for fizzbuzz_formatter: line contents, latency, stall,
// FIFO overflow and mid-line reset.
`timescale 1ns/1ps
module tb_fizzbuzz_formatter;
    localparam int unsigned W = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    fizzbuzz_formatter_if #(.g_width(W)) bus ();

    fizzbuzz_formatter #(.g_width(W), .g_depth(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic f, input logic b, input logic [W-1:0] n);
        bus.i_valid   = 1'b1;
        bus.i_is_fizz = f;
        bus.i_is_buzz = b;
        bus.i_number  = n;
        step();
        bus.i_valid   = 1'b0;
    endtask

    // Waits (bounded) for o_valid, optionally checks latency, then expects s on consecutive cycles.
    task automatic expect_line(input string tag, input string s, input int lat);
        int cyc = 0;
        while (!bus.o_valid && cyc < 100) begin
            step();
            cyc++;
        end
        check({tag, " valid"}, 16'(bus.o_valid), 16'd1);
        if (lat >= 0) check({tag, " latency"}, 16'(cyc), 16'(lat));
        for (int i = 0; i < s.len(); i++) begin
            check($sformatf("%s byte%0d", tag, i), 16'({bus.o_valid, bus.o_data}),
                  16'({1'b1, 8'(s[i])}));
            step();
        end
    endtask

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_is_fizz = 1'b0;
        bus.i_is_buzz = 1'b0;
        bus.i_number  = '0;
        bus.i_ready   = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst empty",    16'(bus.o_empty),    16'd1);
        check("rst full",     16'(bus.o_full),     16'd0);
        check("rst overflow", 16'(bus.o_overflow), 16'd0);
        check("rst valid",    16'(bus.o_valid),    16'd0);
        check("rst data",     16'(bus.o_data),     16'h00);
        check("rst busy",     16'(bus.o_busy),     16'd0);
        rst_n = 1'b1;
        step();

        push(1'b0, 1'b0, 9'd7);
        expect_line("n7", "7\n", 3);
        check("n7 busy after", 16'(bus.o_busy),  16'd0);
        check("n7 empty after", 16'(bus.o_empty), 16'd1);

        push(1'b1, 1'b1, 9'd45);
        expect_line("fb45", "FizzBuzz\n", 2);

        push(1'b0, 1'b0, 9'd0);
        expect_line("n0", "0\n", 3);
        push(1'b0, 1'b0, 9'd40);
        expect_line("n40", "40\n", 7);
        push(1'b0, 1'b0, 9'd305);
        expect_line("n305", "305\n", 6);

        // Stall on the second byte of "Buzz"
        push(1'b0, 1'b1, 9'd5);
        expect_line("b5 head", "B", 2);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall cyc%0d", i), 16'({bus.o_valid, bus.o_data}), 16'({1'b1, 8'h75}));
        end
        bus.i_ready = 1'b1;
        expect_line("b5 tail", "uzz\n", -1);

        // Ten back-to-back pushes into an 8-deep FIFO with the sink stalled
        bus.i_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus.i_valid   = 1'b1;
            bus.i_is_fizz = (k % 3 == 0);
            bus.i_is_buzz = (k % 5 == 0);
            bus.i_number  = W'(k);
            step();
        end
        bus.i_valid = 1'b0;
        check("ovf full",     16'(bus.o_full),     16'd1);
        check("ovf sticky",   16'(bus.o_overflow), 16'd1);
        check("ovf empty",    16'(bus.o_empty),    16'd0);
        check("ovf head",     16'({bus.o_valid, bus.o_data}), 16'({1'b1, 8'h31}));
        repeat (3) step();
        check("ovf held",     16'(bus.o_overflow), 16'd1);
        bus.i_ready = 1'b1;
        expect_line("d1", "1\n", -1);
        expect_line("d2", "2\n", -1);
        expect_line("d3", "Fizz\n", -1);
        expect_line("d4", "4\n", -1);
        expect_line("d5", "Buzz\n", -1);
        expect_line("d6", "Fizz\n", -1);
        expect_line("d7", "7\n", -1);
        expect_line("d8", "8\n", -1);
        expect_line("d9", "Fizz\n", -1);
        repeat (12) step();
        check("drain valid", 16'(bus.o_valid),    16'd0);
        check("drain empty", 16'(bus.o_empty),    16'd1);
        check("drain busy",  16'(bus.o_busy),     16'd0);
        check("drain ovf",   16'(bus.o_overflow), 16'd1);

        // Reset in the middle of "Fizz"
        push(1'b1, 1'b0, 9'd3);
        expect_line("f3 head", "Fi", 2);
        rst_n = 1'b0;
        #1;
        check("mid rst valid", 16'(bus.o_valid),    16'd0);
        check("mid rst empty", 16'(bus.o_empty),    16'd1);
        check("mid rst ovf",   16'(bus.o_overflow), 16'd0);
        check("mid rst busy",  16'(bus.o_busy),     16'd0);
        check("mid rst data",  16'(bus.o_data),     16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        push(1'b0, 1'b0, 9'd14);
        expect_line("n14", "14\n", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fizzbuzz_formatter.md
Name: fizzbuzz_formatter

Overview:
- Downstream consumer of the fizzbuzz counter/flag stage.
- Captures each (number, fizz, buzz) result into a small FIFO.
- Renders each result as an ASCII line: "Fizz", "Buzz", "FizzBuzz" or the decimal number, each followed by LF (0x0A).
- Streams the line out one byte at a time over a valid/ready interface, toward a UART/console sink.

Parameters:
- g_width, 6, width of i_number; legal range 1..9, so values go up to 511 and need at most 3 decimal digits.
- g_depth, 8, FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  result strobe; one entry is offered per cycle while high.
- i_is_fizz  in  1  fizz flag for the offered entry.
- i_is_buzz  in  1  buzz flag for the offered entry.
- i_number  in  g_width  unsigned counter value for the offered entry.
- o_full  out  1  FIFO full; registered.
- o_empty  out  1  FIFO empty; registered.
- o_overflow  out  1  sticky: an entry was dropped.
- o_busy  out  1  serializer is not in S_IDLE.
- o_valid  out  1  o_data holds a byte.
- o_data  out  8  ASCII byte.
- i_ready  in  1  sink accepts o_data this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release): FIFO pointers and count 0, o_empty=1, o_full=0, o_overflow=0, o_valid=0, o_data=0x00, o_busy=0, FSM=S_IDLE. Reset asserted mid-line abandons the line and empties the FIFO.
- FIFO write: on i_valid && !o_full, store {fizz, buzz, number}.
- FIFO overflow: on i_valid && o_full, drop the entry and set o_overflow; it clears only on reset. o_full is the registered value, so a pop in the same cycle does not rescue the write.
- FIFO read: a simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Flags: o_full and o_empty reflect the count after each edge.
- Serializer FSM, S_IDLE: if !o_empty, pop the head entry.
  - Fizz and/or buzz flag set: load the text and go to S_EMIT.
  - Neither flag set: rem=number, h=0, t=0; go to S_CONV.
- Serializer FSM, S_CONV (one step per cycle):
  - rem>=100: rem-=100, h+=1.
  - else rem>=10: rem-=10, t+=1.
  - else: ones=rem; go to S_EMIT.
  - Cycles spent in S_CONV = h + t + 1.
- Serializer FSM, S_EMIT: o_valid=1 with o_data = byte[idx]. On o_valid && i_ready: idx+=1. After the LF is accepted, idx=0 and the FSM returns to S_IDLE. Pop and first emit never occur in the same cycle.
- Text byte sequences:
  - fizz only: 46 69 7A 7A 0A
  - buzz only: 42 75 7A 7A 0A
  - both: 46 69 7A 7A 42 75 7A 7A 0A
- Number byte sequence: hundreds digit if h!=0; tens digit if h!=0 || t!=0; ones digit always; then 0A. Digit byte = 0x30 + d. Zero prints "0\n".
- Stall: while o_valid && !i_ready, o_data and idx hold. The FIFO keeps accepting entries.
- Latency:
  - Push at edge N makes the entry poppable at edge N+1.
  - Text line: o_valid rises after edge N+2.
  - Number line: o_valid rises (h+t+1) cycles later than a text line.
- Throughput: at most one byte per cycle. Back-to-back lines have exactly one S_IDLE cycle between LF acceptance and the next pop.
- Unused default states return to S_IDLE.

Test Plan:
- Reset, then a single push {fizz=0, buzz=0, number=7} with i_ready=1 -> o_data 0x37, 0x0A on consecutive cycles; first o_valid 3 cycles after the push edge; then o_busy=0, o_empty=1.
- Push number=45 with fizz=1, buzz=1, i_ready=1 -> 46 69 7A 7A 42 75 7A 7A 0A, 9 consecutive valid cycles.
- Push number=0, then number=40, then number=305 (g_width=9), no flags -> "0\n", "40\n", "305\n". For 305 there are 3+0+1=4 cycles in S_CONV.
- Push a buzz entry with i_ready low for 5 cycles on the 2nd byte -> o_data holds 0x75 and o_valid stays high for the whole stall; the stream completes after i_ready rises.
- Hold i_ready=0 and push 10 consecutive entries with g_depth=8 -> one entry pops and the FIFO refills to 8, o_full=1, o_overflow=1 and stays 1; after draining exactly 9 lines appear, in order.
- Assert i_rst_n=0 mid-line, then release -> o_valid=0, o_empty=1, o_overflow=0 immediately; the next pushed entry formats correctly from byte 0.
